// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_ctrl data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } dmem_size_e;

    // Big-endian lanes: byte offset 0 is bits 31:24, i.e. be[3].
    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane unit: store replication / byte enables and load
// lane extraction with sign or zero extension (big-endian bus).
import dmem_pkg::*;

module dmem_lane_fmt (
    input  dmem_size_e  size,
    input  logic [1:0]  offset,
    input  logic        sext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Byte at offset o lives at bits [31-8o -: 8]; shift it down to 7:0.
    assign shifted = rdata >> {~offset, 3'b000};
    assign lane_b  = shifted[7:0];
    assign lane_h  = offset[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        be        = BE_WORD;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                be        = BE_BYTE0 >> offset;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sext & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                be        = offset[1] ? BE_HALF_LO : BE_HALF_HI;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sext & lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller with request/ack bus and stall output.
// Optional LL/SC link tracking is enabled by defining DMEM_LLSC_EN.
import dmem_pkg::*;

module dmem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemHalf,
    input  logic        MemByte,
    input  logic        MemSignExtend,
    input  logic        LLSC,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    output logic [31:0] MemReadData,
    output logic        StallController,
    output logic        AddrErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    dmem_state_e state, state_n;
    dmem_size_e  size_live, size_q, fmt_size;
    logic        access, misalign, is_sc, sc_fail, start, latch;
    logic [1:0]  off_q, fmt_off;
    logic        sext_q, fmt_sext, we_q, sc_q, cur_we, cur_sc;
    logic [29:0] addr_q;
    logic [3:0]  be_q, lane_be;
    logic [31:0] wdata_q, lane_wdata, lane_load, rdata_q;

    assign size_live = MemByte ? SZ_BYTE : (MemHalf ? SZ_HALF : SZ_WORD);
    assign misalign  = (size_live == SZ_HALF && ALUResult[0]) ||
                       (size_live == SZ_WORD && ALUResult[1:0] != 2'b00);
    // Gating with rst keeps mem_req low during reset even if EX/MEM is still driven.
    assign access    = (MemRead | MemWrite) & ~rst;
    assign is_sc     = LLSC & MemWrite;
    assign start     = (state == IDLE) && access && !misalign;

`ifdef DMEM_LLSC_EN
    logic        link_valid, ll_q, cur_ll;
    logic [29:0] link_addr;
    assign sc_fail = is_sc && !(link_valid && link_addr == ALUResult[31:2]);
    assign cur_ll  = (state == WAIT) ? ll_q : (LLSC & MemRead & ~MemWrite);
`else
    assign sc_fail = 1'b0;
`endif

    // While waiting, format from captured controls so the result is self-contained.
    assign fmt_size = (state == WAIT) ? size_q : size_live;
    assign fmt_off  = (state == WAIT) ? off_q  : ALUResult[1:0];
    assign fmt_sext = (state == WAIT) ? sext_q : MemSignExtend;
    assign cur_we   = (state == WAIT) ? we_q   : MemWrite;
    assign cur_sc   = (state == WAIT) ? sc_q   : is_sc;

    dmem_lane_fmt u_lane (
        .size       (fmt_size),
        .offset     (fmt_off),
        .sext       (fmt_sext),
        .store_data (ReadData2),
        .rdata      (mem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    always_comb begin
        state_n         = state;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = ALUResult[31:2];
        mem_be          = lane_be;
        mem_wdata       = lane_wdata;
        StallController = 1'b0;
        AddrErr         = 1'b0;
        latch           = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misalign) begin
                        AddrErr = 1'b1;
                    end else if (sc_fail) begin
                        state_n = DONE;
                    end else begin
                        mem_req         = 1'b1;
                        mem_we          = MemWrite;
                        StallController = 1'b1;
                        latch           = mem_ack;
                        state_n         = mem_ack ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                mem_req         = 1'b1;
                mem_we          = we_q;
                mem_addr        = addr_q;
                mem_be          = be_q;
                mem_wdata       = wdata_q;
                StallController = 1'b1;
                latch           = mem_ack;
                if (mem_ack) state_n = DONE;
            end
            DONE: begin
                if (!Stall) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sc_q    <= 1'b0;
            size_q  <= SZ_WORD;
            off_q   <= '0;
            sext_q  <= 1'b0;
        end else begin
            if (start) begin
                addr_q  <= ALUResult[31:2];
                be_q    <= lane_be;
                wdata_q <= lane_wdata;
                we_q    <= MemWrite;
                sc_q    <= is_sc;
                size_q  <= size_live;
                off_q   <= ALUResult[1:0];
                sext_q  <= MemSignExtend;
            end
            if (start && sc_fail)
                rdata_q <= '0;
            else if (latch)
                rdata_q <= cur_we ? {31'd0, cur_sc} : lane_load;
        end
    end

`ifdef DMEM_LLSC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
            ll_q       <= 1'b0;
        end else begin
            if (start) ll_q <= LLSC & MemRead & ~MemWrite;
            if (start && MemWrite && (is_sc || link_addr == ALUResult[31:2]))
                link_valid <= 1'b0;
            else if (latch && cur_ll) begin
                link_valid <= 1'b1;
                link_addr  <= mem_addr;
            end
        end
    end
`endif

    assign MemReadData = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl; inputs change on negedge,
// outputs are sampled 1 time unit later.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst, Stall;
    logic        MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC;
    logic [31:0] ALUResult, ReadData2, MemReadData, mem_wdata, mem_rdata;
    logic        StallController, AddrErr, mem_req, mem_we, mem_ack;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;

    int total  = 0;
    int passed = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .Stall           (Stall),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .MemHalf         (MemHalf),
        .MemByte         (MemByte),
        .MemSignExtend   (MemSignExtend),
        .LLSC            (LLSC),
        .ALUResult       (ALUResult),
        .ReadData2       (ReadData2),
        .MemReadData     (MemReadData),
        .StallController (StallController),
        .AddrErr         (AddrErr),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic hf, input logic by,
                         input logic se, input logic ll, input logic [31:0] a,
                         input logic [31:0] wd);
        MemRead = rd; MemWrite = wr; MemHalf = hf; MemByte = by;
        MemSignExtend = se; LLSC = ll; ALUResult = a; ReadData2 = wd;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; Stall = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        idle_in();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_stall", {31'd0, StallController}, 32'd0);
        chk("rst_aerr",  {31'd0, AddrErr}, 32'd0);
        chk("rst_mrd",   MemReadData, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Word store 0x100 <- DEADBEEF, ack in the third stall cycle
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF);
        #1;
        stall_cnt = int'(StallController);
        chk("sw_req",   {31'd0, mem_req}, 32'd1);
        chk("sw_we",    {31'd0, mem_we}, 32'd1);
        chk("sw_be",    {28'd0, mem_be}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_addr",  {2'b00, mem_addr}, 32'h40);
        @(negedge clk); #1;
        stall_cnt += int'(StallController);
        chk("sw_wait_req",  {31'd0, mem_req}, 32'd1);
        chk("sw_wait_addr", {2'b00, mem_addr}, 32'h40);
        @(negedge clk); mem_ack = 1'b1; #1;
        stall_cnt += int'(StallController);
        @(negedge clk); mem_ack = 1'b0; idle_in(); #1;
        stall_cnt += int'(StallController);
        chk("sw_done_req", {31'd0, mem_req}, 32'd0);
        chk("sw_stall_cycles", stall_cnt, 32'd3);

        // Byte load 0x103, sign-extended, ack in request cycle
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h103, 32'h0);
        mem_rdata = 32'h112233F0; mem_ack = 1'b1; #1;
        chk("lb_be",    {28'd0, mem_be}, 32'h1);
        chk("lb_we",    {31'd0, mem_we}, 32'd0);
        chk("lb_stall", {31'd0, StallController}, 32'd1);
        @(negedge clk); mem_ack = 1'b0; idle_in(); #1;
        chk("lb_sext",   MemReadData, 32'hFFFFFFF0);
        chk("lb_dstall", {31'd0, StallController}, 32'd0);

        // Same load, zero-extended
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h103, 32'h0);
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; idle_in(); #1;
        chk("lbu_zext", MemReadData, 32'h000000F0);

        // Half store 0x102 <- ABCD
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102, 32'h0000ABCD);
        mem_ack = 1'b1; #1;
        chk("sh_be",    {28'd0, mem_be}, 32'h3);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        @(negedge clk); mem_ack = 1'b0; idle_in();

        // Misaligned half store 0x101
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h101, 32'h0000ABCD);
        #1;
        chk("mis_aerr",  {31'd0, AddrErr}, 32'd1);
        chk("mis_req",   {31'd0, mem_req}, 32'd0);
        chk("mis_stall", {31'd0, StallController}, 32'd0);
        @(negedge clk); idle_in(); #1;
        chk("mis_aerr_clr", {31'd0, AddrErr}, 32'd0);

        // Half load at 0x002 (lower half), zero-extended
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2, 32'h0);
        mem_rdata = 32'h1234_8765; mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; idle_in(); #1;
        chk("lhu_lo", MemReadData, 32'h00008765);

        // Word load completes while the pipeline is stalled
        @(negedge clk);
        Stall = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_rdata = 32'hCAFEF00D; mem_ack = 1'b1; #1;
        chk("stl_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk); mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stl_hold_req", {31'd0, mem_req}, 32'd0);
            chk("stl_hold_mrd", MemReadData, 32'hCAFEF00D);
            @(negedge clk);
        end
        Stall = 1'b0; #1;
        chk("stl_rel_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk); idle_in();

        // Reset during WAIT
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk); #1;
        chk("rw_wait_req", {31'd0, mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rw_async_req", {31'd0, mem_req}, 32'd0);
        chk("rw_mrd_clr",   MemReadData, 32'd0);
        @(negedge clk); rst = 1'b0; idle_in(); mem_ack = 1'b1; #1;
        chk("rw_stray_stall", {31'd0, StallController}, 32'd0);
        @(negedge clk); mem_ack = 1'b0; #1;
        chk("rw_stray_mrd", MemReadData, 32'd0);

`ifdef DMEM_LLSC_EN
        // LL 0x200, SC 0x200 succeeds, second SC fails
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
        mem_rdata = 32'h5555AAAA; mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; idle_in(); #1;
        chk("ll_data", MemReadData, 32'h5555AAAA);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0BADF00D);
        mem_ack = 1'b1; #1;
        chk("sc1_req", {31'd0, mem_req}, 32'd1);
        chk("sc1_we",  {31'd0, mem_we}, 32'd1);
        @(negedge clk); mem_ack = 1'b0; idle_in(); #1;
        chk("sc1_flag", MemReadData, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0BADF00D);
        #1;
        chk("sc2_req",   {31'd0, mem_req}, 32'd0);
        chk("sc2_stall", {31'd0, StallController}, 32'd0);
        @(negedge clk); idle_in(); #1;
        chk("sc2_flag", MemReadData, 32'd0);
`else
        // SC without link tracking is a plain word store reporting success
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0BADF00D);
        mem_ack = 1'b1; #1;
        chk("sc_req", {31'd0, mem_req}, 32'd1);
        chk("sc_be",  {28'd0, mem_be}, 32'hF);
        @(negedge clk); mem_ack = 1'b0; idle_in(); #1;
        chk("sc_flag", MemReadData, 32'd1);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller for the MEM stage of the MIPS III pipeline. It consumes the EX/MEM control and data signals (MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC, ALUResult, ReadData2) and drives a word-wide request/acknowledge data bus. It returns formatted load data as MemReadData toward MEM/WB and asserts StallController while an access is outstanding. Stores use byte lanes, loads are sign/zero extended, and LL/SC reservation tracking is optional.

## Interface
- No parameters; bus and word widths are fixed at 32 bits.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- Stall  in  1  global pipeline stall; holds a completed result.
- MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC  in  1 each  EX/MEM control.
- ALUResult  in  32  effective byte address.
- ReadData2  in  32  store data.
- MemReadData  out  32  load result, or SC success flag.
- StallController  out  1  access in progress; the pipeline must hold.
- AddrErr  out  1  misaligned access; one cycle, combinational.
- mem_req  out  1  bus request.
- mem_we  out  1  write when 1.
- mem_addr  out  30  word address, ALUResult[31:2].
- mem_be  out  4  byte enables; bit 3 selects bits 31:24.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  single-cycle completion.

## Operation
- The bus is big-endian. Byte offset 0 maps to bits 31:24.
- Access size: MemByte gives a byte, else MemHalf gives a half, else a word. MemByte takes priority over MemHalf.
- An access is misaligned when a half has ALUResult[0]=1, or a word has ALUResult[1:0]≠0.
  - On misalignment, AddrErr=1, no bus request is made, StallController=0, and the link is unchanged.
- Store lanes:
  - Byte: mem_be = 4'b1000>>addr[1:0], mem_wdata = {4{ReadData2[7:0]}}.
  - Half: mem_be = addr[1] ? 4'b0011 : 4'b1100, mem_wdata = {2{ReadData2[15:0]}}.
  - Word: mem_be = 4'b1111.
- Loads select the addressed lane, then sign-extend if MemSignExtend, else zero-extend. Word loads pass through. mem_be reflects the load size.
- FSM states:
  - IDLE: when a valid (aligned) access is present, assert mem_req and StallController combinationally. If mem_ack is seen the same cycle, go to DONE; otherwise go to WAIT.
  - WAIT: hold mem_req, mem_we, mem_addr, mem_be and mem_wdata stable and keep StallController=1. On mem_ack, latch the result into rdata_q and go to DONE.
  - DONE: mem_req=0, StallController=0, MemReadData=rdata_q. Go to IDLE when Stall=0; stay in DONE while Stall=1.
- DONE always leaves to IDLE, never directly into a new access. This prevents the same stalled instruction from triggering twice.
- MemRead and MemWrite both high is treated as a write.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, StallController 0, AddrErr 0, rdata_q 0, MemReadData 0, link clear.
- mem_addr, mem_be and mem_wdata are don't-care while mem_req=0.
- Minimum latency, with mem_ack in the request cycle: 1 stall cycle, then 1 DONE cycle.
- A mem_ack after N wait cycles gives N+1 stall cycles.
- rst mid-access drops mem_req immediately and discards any pending mem_ack.
- mem_ack while in IDLE with no request, or in DONE, is ignored.

## Configuration
- DMEM_LLSC_EN defined:
  - LL (LLSC & MemRead) sets link_valid and link_addr = ALUResult[31:2] when its ack arrives.
  - SC (LLSC & MemWrite) checks link_valid and a matching address.
    - On success, the store is issued and MemReadData is 1.
    - On failure, there is no bus access, StallController stays 0, the FSM goes straight to DONE with rdata_q = 0, and the result is visible the next cycle.
  - Any SC clears the link.
  - Any other store to link_addr also clears the link.
- DMEM_LLSC_EN undefined:
  - LLSC is ignored; LL behaves as a word load.
  - SC behaves as a word store with MemReadData = 1.
  - No link state is synthesized.

## Structure
- Shared package dmem_pkg holds:
  - the dmem_state_e enum (IDLE, WAIT, DONE);
  - the access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the BE_* byte-enable constants.
- Sub-module dmem_lane_fmt is a combinational lane unit: store replication and byte enables, plus load extraction and extension.

## Test plan
- Word store to 0x100 of 0xDEADBEEF with ack after 2 cycles:
  - mem_be=1111, mem_wdata=0xDEADBEEF, mem_addr=0x40, StallController high 3 cycles, then DONE.
- Byte load from 0x103 with mem_rdata=0x112233F0 and MemSignExtend=1:
  - MemReadData=0xFFFFFFF0; with MemSignExtend=0, MemReadData=0x000000F0.
- Half store to 0x102 of 0x0000ABCD:
  - mem_be=0011, mem_wdata=0xABCDABCD; a half access to 0x101 gives AddrErr=1, no mem_req.
- Load completes while Stall=1 for 3 cycles:
  - the FSM stays in DONE, MemReadData holds, and no second mem_req is issued.
- rst asserted during WAIT:
  - mem_req falls asynchronously, state is IDLE, and a later mem_ack is ignored.
- With DMEM_LLSC_EN:
  - LL 0x200, then SC 0x200 gives a bus write and MemReadData=1.
  - A second SC to 0x200 gives no mem_req and MemReadData=0.
